// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter sharing one peripheral reg-bus segment between several masters.
// Holds each grant until the slave completes, or aborts with an error after a response timeout.
module periph_reg_arbiter #(
   parameter int NumMasters    = 2,
   parameter int AW            = 32,
   parameter int DW            = 32,
   parameter int TimeoutCycles = 256,
   parameter int IdxW          = $clog2(NumMasters)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumMasters-1:0]      mst_valid_i,
   input  logic [NumMasters*AW-1:0]   mst_addr_i,
   input  logic [NumMasters-1:0]      mst_write_i,
   input  logic [NumMasters*DW-1:0]   mst_wdata_i,
   input  logic [NumMasters*DW/8-1:0] mst_wstrb_i,
   output logic [NumMasters-1:0]      mst_ready_o,
   output logic [NumMasters*DW-1:0]   mst_rdata_o,
   output logic [NumMasters-1:0]      mst_error_o,
   output logic                       slv_valid_o,
   output logic [AW-1:0]              slv_addr_o,
   output logic                       slv_write_o,
   output logic [DW-1:0]              slv_wdata_o,
   output logic [DW/8-1:0]            slv_wstrb_o,
   input  logic                       slv_ready_i,
   input  logic [DW-1:0]              slv_rdata_i,
   input  logic                       slv_error_i,
   output logic                       busy_o,
   output logic [IdxW-1:0]            grant_idx_o,
   output logic                       timeout_o
);

   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam int SW   = DW / 8;

   // Handshake: a master holds valid and its fields stable until it sees its ready pulse;
   // the slave may raise slv_ready_i combinationally in the first BUSY cycle.
   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0] grant_idx_q, grant_idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] winner;
   logic            found;
   logic [IdxW-1:0] next_ptr;
   int              cand;
   int              gidx;

   assign gidx     = int'(grant_idx_q);
   assign next_ptr = (grant_idx_q == IdxW'(NumMasters - 1)) ? '0 : grant_idx_q + 1'b1;

   // First requesting master at or above rr_ptr, wrapping past the top index.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = 0;
      for (int i = 0; i < NumMasters; i++) begin
         cand = (int'(rr_ptr_q) + i) % NumMasters;
         if (!found && mst_valid_i[cand]) begin
            found  = 1'b1;
            winner = IdxW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_idx_d = grant_idx_q;
      cnt_d       = cnt_q;
      slv_valid_o = 1'b0;
      slv_addr_o  = '0;
      slv_write_o = 1'b0;
      slv_wdata_o = '0;
      slv_wstrb_o = '0;
      mst_ready_o = '0;
      mst_rdata_o = '0;
      mst_error_o = '0;
      timeout_o   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (found) begin
               grant_idx_d = winner;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (!mst_valid_i[gidx]) begin
               // Master withdrew mid-transfer: drop the slave request, leave rr_ptr alone.
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               slv_valid_o = 1'b1;
               slv_addr_o  = mst_addr_i[gidx*AW +: AW];
               slv_write_o = mst_write_i[gidx];
               slv_wdata_o = mst_wdata_i[gidx*DW +: DW];
               slv_wstrb_o = mst_wstrb_i[gidx*SW +: SW];
               cnt_d       = cnt_q + 1'b1;
               if (slv_ready_i) begin
                  mst_ready_o[gidx]            = 1'b1;
                  mst_rdata_o[gidx*DW +: DW]   = slv_rdata_i;
                  mst_error_o[gidx]            = slv_error_i;
                  rr_ptr_d                     = next_ptr;
                  cnt_d                        = '0;
                  state_d                      = IDLE;
               end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                  mst_ready_o[gidx] = 1'b1;
                  mst_error_o[gidx] = 1'b1;
                  timeout_o         = 1'b1;
                  rr_ptr_d          = next_ptr;
                  cnt_d             = '0;
                  state_d           = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_idx_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_idx_q <= grant_idx_d;
         cnt_q       <= cnt_d;
      end
   end

   assign busy_o      = (state_q == BUSY);
   assign grant_idx_o = grant_idx_q;

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Directed bench for periph_reg_arbiter: two masters, timeout shortened to 8 cycles.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_periph_reg_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [NM-1:0]   mst_valid_i;
   logic [NM*AW-1:0] mst_addr_i;
   logic [NM-1:0]   mst_write_i;
   logic [NM*DW-1:0] mst_wdata_i;
   logic [NM*DW/8-1:0] mst_wstrb_i;
   logic [NM-1:0]   mst_ready_o;
   logic [NM*DW-1:0] mst_rdata_o;
   logic [NM-1:0]   mst_error_o;
   logic            slv_valid_o;
   logic [AW-1:0]   slv_addr_o;
   logic            slv_write_o;
   logic [DW-1:0]   slv_wdata_o;
   logic [DW/8-1:0] slv_wstrb_o;
   logic            slv_ready_i;
   logic [DW-1:0]   slv_rdata_i;
   logic            slv_error_i;
   logic            busy_o;
   logic [0:0]      grant_idx_o;
   logic            timeout_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   periph_reg_arbiter #(
      .NumMasters(NM), .AW(AW), .DW(DW), .TimeoutCycles(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .mst_valid_i(mst_valid_i), .mst_addr_i(mst_addr_i), .mst_write_i(mst_write_i),
      .mst_wdata_i(mst_wdata_i), .mst_wstrb_i(mst_wstrb_i),
      .mst_ready_o(mst_ready_o), .mst_rdata_o(mst_rdata_o), .mst_error_o(mst_error_o),
      .slv_valid_o(slv_valid_o), .slv_addr_o(slv_addr_o), .slv_write_o(slv_write_o),
      .slv_wdata_o(slv_wdata_o), .slv_wstrb_o(slv_wstrb_o),
      .slv_ready_i(slv_ready_i), .slv_rdata_i(slv_rdata_i), .slv_error_i(slv_error_i),
      .busy_o(busy_o), .grant_idx_o(grant_idx_o), .timeout_o(timeout_o)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      mst_valid_i = '0; mst_addr_i = '0; mst_write_i = '0;
      mst_wdata_i = '0; mst_wstrb_i = '0;
      slv_ready_i = 1'b0; slv_rdata_i = '0; slv_error_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      step(); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (grant_idx_o !== 1'b0) begin failures++; $display("FAIL reset_grant: got %h want 0", grant_idx_o); end
      checks++; if (slv_valid_o !== 1'b0) begin failures++; $display("FAIL reset_slv_valid: got %b want 0", slv_valid_o); end
      checks++; if (mst_ready_o !== 2'b00) begin failures++; $display("FAIL reset_ready: got %b want 00", mst_ready_o); end
      checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
      checks++; if (slv_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", slv_addr_o); end
      step();
      rst_ni = 1'b1;
   endtask

   task automatic test_single_read();
      step();
      mst_valid_i = 2'b01; mst_addr_i[31:0] = 32'h2000_0010; mst_write_i = 2'b00;
      #1;
      checks++; if (slv_valid_o !== 1'b0) begin failures++; $display("FAIL single_idle_valid: got %b want 0", slv_valid_o); end
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 3) begin slv_ready_i = 1'b1; slv_rdata_i = 32'hCAFE_F00D; end
         #1;
         checks++; if (slv_valid_o !== 1'b1) begin failures++; $display("FAIL single_busy_valid c%0d: got %b want 1", c, slv_valid_o); end
         checks++; if (slv_addr_o !== 32'h2000_0010) begin failures++; $display("FAIL single_addr c%0d: got %h want 20000010", c, slv_addr_o); end
         checks++; if (mst_ready_o !== ((c == 3) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL single_ready c%0d: got %b", c, mst_ready_o); end
      end
      checks++; if (mst_rdata_o !== 64'h0000_0000_CAFE_F00D) begin failures++; $display("FAIL single_rdata: got %h want 00000000cafef00d", mst_rdata_o); end
      checks++; if (mst_error_o !== 2'b00) begin failures++; $display("FAIL single_error: got %b want 00", mst_error_o); end
      step();
      clear_inputs();
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL single_back_idle: got %b want 0", busy_o); end
      checks++; if (mst_ready_o !== 2'b00) begin failures++; $display("FAIL single_one_pulse: got %b want 00", mst_ready_o); end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_ready [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      logic        exp_grant [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [63:0] exp_rd;
      logic [31:0] rd;
      int          g;
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      mst_valid_i = 2'b11; mst_addr_i = {32'h0000_0200, 32'h0000_0100};
      slv_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) step();
         rd = 32'hA5A5_0000 + 32'(c);
         slv_rdata_i = rd;
         #1;
         g = int'(exp_grant[c]);
         exp_rd = '0;
         if (exp_ready[c] != 2'b00) exp_rd[g*32 +: 32] = rd;
         checks++; if (mst_ready_o !== exp_ready[c]) begin failures++; $display("FAIL rr_ready c%0d: got %b want %b", c, mst_ready_o, exp_ready[c]); end
         checks++; if (grant_idx_o !== exp_grant[c]) begin failures++; $display("FAIL rr_grant c%0d: got %h want %h", c, grant_idx_o, exp_grant[c]); end
         checks++; if (mst_rdata_o !== exp_rd) begin failures++; $display("FAIL rr_rdata c%0d: got %h want %h", c, mst_rdata_o, exp_rd); end
         if (exp_ready[c] != 2'b00) begin
            checks++; if (slv_addr_o !== ((g == 1) ? 32'h200 : 32'h100)) begin failures++; $display("FAIL rr_addr c%0d: got %h", c, slv_addr_o); end
         end
      end
      step();
      clear_inputs();
   endtask

   task automatic test_zero_wait_write();
      mst_valid_i = 2'b10; mst_addr_i[63:32] = 32'h2000_1004; mst_write_i = 2'b10;
      mst_wdata_i[63:32] = 32'h1234_5678; mst_wstrb_i[7:4] = 4'hF; slv_ready_i = 1'b1;
      #1;
      checks++; if (slv_valid_o !== 1'b0) begin failures++; $display("FAIL zw_idle_valid: got %b want 0", slv_valid_o); end
      step(); #1;
      checks++; if (slv_valid_o !== 1'b1) begin failures++; $display("FAIL zw_valid: got %b want 1", slv_valid_o); end
      checks++; if (slv_addr_o !== 32'h2000_1004) begin failures++; $display("FAIL zw_addr: got %h want 20001004", slv_addr_o); end
      checks++; if (slv_write_o !== 1'b1) begin failures++; $display("FAIL zw_write: got %b want 1", slv_write_o); end
      checks++; if (slv_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL zw_wdata: got %h want 12345678", slv_wdata_o); end
      checks++; if (slv_wstrb_o !== 4'hF) begin failures++; $display("FAIL zw_wstrb: got %h want f", slv_wstrb_o); end
      checks++; if (mst_ready_o !== 2'b10) begin failures++; $display("FAIL zw_ready: got %b want 10", mst_ready_o); end
      checks++; if (grant_idx_o !== 1'b1) begin failures++; $display("FAIL zw_grant: got %h want 1", grant_idx_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_timeout(input logic coincident);
      mst_valid_i = 2'b01; mst_addr_i[31:0] = 32'h2000_0040;
      slv_rdata_i = 32'hDEAD_BEEF;
      for (int c = 1; c <= TO; c++) begin
         step();
         if (coincident && c == TO) begin
            slv_ready_i = 1'b1; slv_error_i = 1'b1; slv_rdata_i = 32'h55AA_55AA;
         end
         #1;
         checks++; if (slv_valid_o !== 1'b1) begin failures++; $display("FAIL to_valid co%0d c%0d: got %b want 1", coincident, c, slv_valid_o); end
         if (c < TO) begin
            checks++; if (mst_ready_o !== 2'b00) begin failures++; $display("FAIL to_early_ready co%0d c%0d: got %b want 00", coincident, c, mst_ready_o); end
            checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL to_early_pulse co%0d c%0d: got %b want 0", coincident, c, timeout_o); end
         end
      end
      checks++; if (mst_ready_o !== 2'b01) begin failures++; $display("FAIL to_ready co%0d: got %b want 01", coincident, mst_ready_o); end
      checks++; if (mst_error_o !== 2'b01) begin failures++; $display("FAIL to_error co%0d: got %b want 01", coincident, mst_error_o); end
      checks++; if (timeout_o !== !coincident) begin failures++; $display("FAIL to_pulse co%0d: got %b want %b", coincident, timeout_o, !coincident); end
      checks++; if (mst_rdata_o !== (coincident ? 64'h55AA_55AA : 64'h0)) begin failures++; $display("FAIL to_rdata co%0d: got %h", coincident, mst_rdata_o); end
      step();
      clear_inputs();
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL to_idle co%0d: got %b want 0", coincident, busy_o); end
      checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL to_one_pulse co%0d: got %b want 0", coincident, timeout_o); end
   endtask

   task automatic test_protocol_abort();
      mst_valid_i = 2'b10; mst_addr_i[63:32] = 32'h2000_2000;
      step(); #1;
      checks++; if (grant_idx_o !== 1'b1) begin failures++; $display("FAIL abort_grant: got %h want 1", grant_idx_o); end
      step();
      mst_valid_i = 2'b00;
      #1;
      checks++; if (slv_valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid: got %b want 0", slv_valid_o); end
      checks++; if (mst_ready_o !== 2'b00) begin failures++; $display("FAIL abort_ready: got %b want 00", mst_ready_o); end
      step(); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL abort_idle: got %b want 0", busy_o); end
      mst_valid_i = 2'b11;
      step();
      slv_ready_i = 1'b1;
      #1;
      checks++; if (grant_idx_o !== 1'b1) begin failures++; $display("FAIL abort_rr_kept: got %h want 1", grant_idx_o); end
      checks++; if (mst_ready_o !== 2'b10) begin failures++; $display("FAIL abort_after_ready: got %b want 10", mst_ready_o); end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      mst_valid_i = 2'b01; mst_addr_i[31:0] = 32'h2000_3000;
      step(); #1;
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL rmid_busy1: got %b want 1", busy_o); end
      step();
      rst_ni = 1'b0;
      #1;
      checks++; if (slv_valid_o !== 1'b1) begin failures++; $display("FAIL rmid_valid_before: got %b want 1", slv_valid_o); end
      step(); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
      checks++; if (slv_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_slv_valid: got %b want 0", slv_valid_o); end
      checks++; if (mst_ready_o !== 2'b00) begin failures++; $display("FAIL rmid_ready: got %b want 00", mst_ready_o); end
      rst_ni = 1'b1;
      mst_valid_i = 2'b10; mst_addr_i = {32'h2000_4000, 32'h0};
      step();
      slv_ready_i = 1'b1;
      #1;
      checks++; if (grant_idx_o !== 1'b1) begin failures++; $display("FAIL rmid_new_grant: got %h want 1", grant_idx_o); end
      checks++; if (slv_addr_o !== 32'h2000_4000) begin failures++; $display("FAIL rmid_new_addr: got %h want 20004000", slv_addr_o); end
      checks++; if (mst_ready_o !== 2'b10) begin failures++; $display("FAIL rmid_new_ready: got %b want 10", mst_ready_o); end
      step();
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_zero_wait_write();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_protocol_abort();
      test_reset_mid();
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/periph_reg_arbiter.md
Name: periph_reg_arbiter

Overview:
Round-robin arbiter that shares the single peripheral register bus (the reg-bus segment feeding the peripheral address decoder/demux) between NumMasters requesters, e.g. the core OBI bridge and a debug/DMA bridge. It grants one master at a time, holds the grant until the slave completes, and enforces a response timeout. A stalled peripheral therefore returns an error instead of hanging the bus.

Parameters:
NumMasters, 2, number of requesting reg-bus masters (>=2, <=8)
AW, 32, address width
DW, 32, data width
TimeoutCycles, 256, BUSY cycles without slave ready before abort (>=2)
IdxW, $clog2(NumMasters), grant index width (derived, do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
mst_valid_i  in  NumMasters  per-master request valid
mst_addr_i  in  NumMasters*AW  per-master address, master m at [m*AW +: AW]
mst_write_i  in  NumMasters  per-master write flag
mst_wdata_i  in  NumMasters*DW  per-master write data
mst_wstrb_i  in  NumMasters*DW/8  per-master byte strobes
mst_ready_o  out  NumMasters  per-master completion pulse
mst_rdata_o  out  NumMasters*DW  per-master read data, valid with ready
mst_error_o  out  NumMasters  per-master error, valid with ready
slv_valid_o  out  1  downstream request valid
slv_addr_o  out  AW  downstream address
slv_write_o  out  1  downstream write
slv_wdata_o  out  DW  downstream write data
slv_wstrb_o  out  DW/8  downstream strobes
slv_ready_i  in  1  downstream completion
slv_rdata_i  in  DW  downstream read data
slv_error_i  in  1  downstream error
busy_o  out  1  arbiter in BUSY
grant_idx_o  out  IdxW  currently or last granted master
timeout_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=IDLE, rr_ptr=0, grant_idx=0, timeout counter=0. All outputs 0 while in IDLE after reset.
- Reg-bus rule: a master holds valid and its fields stable until its ready. The slave may assert ready combinationally in the same cycle as valid.
- IDLE: slv_valid_o=0. If any mst_valid_i is set, the winner is the first set bit searching upward from rr_ptr, wrapping NumMasters-1 -> 0. The winner is registered into grant_idx, and the next state is BUSY. Grant latency: 1 cycle from valid to slv_valid_o.
- BUSY:
  - slv_valid_o=1.
  - slv_addr/write/wdata/wstrb are muxed from mst_*[grant_idx].
  - Counter increments every BUSY cycle.
- BUSY with slv_ready_i=1:
  - mst_ready_o[grant_idx]=1 in the same cycle.
  - mst_rdata_o/mst_error_o for that master driven from slv_rdata_i/slv_error_i.
  - rr_ptr <= (grant_idx+1) mod NumMasters.
  - Counter cleared; next state IDLE.
  - Result: back-to-back transactions from the same master take a minimum of 2 cycles each.
- BUSY with counter == TimeoutCycles-1 and slv_ready_i=0:
  - slv_valid_o still 1 that cycle.
  - mst_ready_o[grant_idx]=1, mst_error_o[grant_idx]=1, mst_rdata_o[grant_idx]=0.
  - timeout_o=1; rr_ptr advanced as above; next state IDLE.
  - If slv_ready_i=1 in that same cycle, it is a normal completion: no timeout, slave error/rdata used.
- BUSY with mst_valid_i[grant_idx]=0 (protocol violation): abort to IDLE next cycle with no ready, no rr_ptr update, slv_valid_o=0 that cycle.
- Non-granted masters: mst_ready_o, mst_rdata_o and mst_error_o are 0 at all times.
- Granted master: mst_rdata_o and mst_error_o are 0 except in its ready cycle.
- Downstream fields in IDLE: 0.
- grant_idx_o = grant_idx register at all times. busy_o = (state==BUSY).
- Reset asserted mid-transaction: next edge forces IDLE. No ready is issued to the in-flight master; the slave sees valid drop.
- Fairness: with all masters requesting continuously, each master is served exactly once per NumMasters transactions.
- Counter width: $clog2(TimeoutCycles+1). The counter never wraps because it is cleared on each exit from BUSY.

Test Plan:
- Single master: m0 read addr 0x2000_0010, slave ready after 3 BUSY cycles with rdata 0xCAFE_F00D -> slv_valid_o rises 1 cycle after mst_valid_i; mst_ready_o[0] pulses once with rdata 0xCAFE_F00D, error 0.
- Contention, NumMasters=2: both valid at reset release, slave always ready -> grant order 0,1,0,1. Each mst_ready_o pulses every 4 cycles; grant_idx_o alternates.
- Zero-wait write: m1 write 0x2000_1004 data 0x1234_5678 wstrb 0xF, slv_ready_i=1 combinationally -> downstream fields match exactly in the BUSY cycle; mst_ready_o[1]=1 in that same cycle.
- Timeout: TimeoutCycles=8, slave never ready -> after exactly 8 BUSY cycles mst_ready_o[0]=1, mst_error_o[0]=1, rdata 0, timeout_o pulses 1 cycle, state returns to IDLE.
- Ready coincident with timeout: slave ready with error=1 exactly on cycle 8 -> timeout_o=0, mst_error_o[0]=1 from the slave.
- Reset mid-transaction: assert rst_ni=0 in the 2nd BUSY cycle -> next edge busy_o=0, slv_valid_o=0, no mst_ready_o. After release, a new request from m1 is granted first (rr_ptr=0, m0 idle).
